// File: rtl/simon_pkg.sv
// Shared Simon game types: slot geometry, quarter codes, checker state encoding.
package simon_pkg;

    localparam int SLOT_W    = 4;
    localparam int MAX_SLOTS = 10;
    localparam int SEQ_W     = SLOT_W * MAX_SLOTS;

    localparam logic [SLOT_W-1:0] Q_RED    = 4'b0001;
    localparam logic [SLOT_W-1:0] Q_GREEN  = 4'b0010;
    localparam logic [SLOT_W-1:0] Q_BLUE   = 4'b0100;
    localparam logic [SLOT_W-1:0] Q_YELLOW = 4'b1000;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_PRESS,
        WAIT_RELEASE,
        WON,
        LOST
    } chk_state_t;

    // Equivalent to seq[4*idx +: 4]; a shift keeps the index arithmetic width-clean.
    function automatic logic [SLOT_W-1:0] slot_of(input logic [SEQ_W-1:0] seq,
                                                  input logic [3:0]       idx);
        logic [SEQ_W-1:0] shifted;
        shifted = seq >> {idx, 2'b00};
        return shifted[SLOT_W-1:0];
    endfunction

endpackage

// File: rtl/key_debouncer.sv
// Purpose: 2-flop synchronizer plus stability counter for a 4-bit raw button vector.
// Latency: keyStable follows a raw change after 2 + DEBOUNCE_CYCLES cycles.
// Backpressure: none; free-running, output is always valid.
module key_debouncer #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic       CLOCK_50,
    input  logic       resetn,
    input  logic [3:0] keys,
    output logic [3:0] keyStable
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    logic [3:0]       sync1;
    logic [3:0]       sync2;
    logic [CNT_W-1:0] stable_cnt;

    always_ff @(posedge CLOCK_50) begin
        if (!resetn) begin
            sync1      <= '0;
            sync2      <= '0;
            stable_cnt <= '0;
            keyStable  <= '0;
        end else begin
            sync1 <= keys;
            sync2 <= sync1;
            // sync1 != sync2 means sync2 is about to change, so its run of equal values ends here.
            if ((sync1 != sync2) || (sync2 == keyStable)) begin
                stable_cnt <= '0;
            end else if (stable_cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                keyStable  <= sync2;
                stable_cnt <= '0;
            end else begin
                stable_cnt <= stable_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/player_input_checker.sv
// Purpose: checks debounced quarter-button presses against the latched Simon sequence, slot by slot.
// Latency: state reacts one cycle after keyStable changes (raw key to state: 3 + DEBOUNCE_CYCLES).
// Backpressure: none; a start edge restarts the round from any state, results held as levels.
module player_input_checker
    import simon_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int TIMEOUT_CYCLES  = 150000000
) (
    input  logic             CLOCK_50,
    input  logic             resetn,
    input  logic             start,
    input  logic [SEQ_W-1:0] sequenceBits,
    input  logic [3:0]       sequenceSize,
    input  logic [3:0]       keys,
    output logic [3:0]       pressedQuarter,
    output logic             busy,
    output logic [3:0]       matchCount,
    output logic             roundWon,
    output logic             roundLost
);

    localparam int TIMER_W = 28;

    chk_state_t       state, state_nxt;
    logic [3:0]       keyStable;
    logic [3:0]       key_prev;
    logic             start_q;
    logic [SEQ_W-1:0] seq_l;
    logic [3:0]       size_l;
    logic [3:0]       idx, idx_nxt;
    logic [3:0]       match_cnt, match_nxt;
    logic [TIMER_W-1:0] timer, timer_nxt;

    logic       start_edge;
    logic       press_evt;
    logic [3:0] size_clamped;

    key_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .CLOCK_50 (CLOCK_50),
        .resetn   (resetn),
        .keys     (keys),
        .keyStable(keyStable)
    );

    assign start_edge   = start && !start_q;
    assign press_evt    = (key_prev == 4'b0000) && (keyStable != 4'b0000);
    assign size_clamped = (sequenceSize > 4'(MAX_SLOTS)) ? 4'(MAX_SLOTS) : sequenceSize;

    always_ff @(posedge CLOCK_50) begin
        if (!resetn) begin
            state     <= IDLE;
            key_prev  <= '0;
            start_q   <= 1'b0;
            seq_l     <= '0;
            size_l    <= '0;
            idx       <= '0;
            match_cnt <= '0;
            timer     <= '0;
        end else begin
            state     <= state_nxt;
            key_prev  <= keyStable;
            start_q   <= start;
            idx       <= idx_nxt;
            match_cnt <= match_nxt;
            timer     <= timer_nxt;
            if (start_edge) begin
                seq_l  <= sequenceBits;
                size_l <= size_clamped;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        match_nxt = match_cnt;
        timer_nxt = timer;

        if (start_edge) begin
            idx_nxt   = '0;
            match_nxt = '0;
            timer_nxt = '0;
            state_nxt = (size_clamped == 4'd0) ? WON : WAIT_PRESS;
        end else begin
            unique case (state)
                WAIT_PRESS: begin
                    // A press evaluated in the final timer cycle takes priority over the timeout.
                    if (press_evt) begin
                        if (keyStable == slot_of(seq_l, idx)) begin
                            idx_nxt   = idx + 4'd1;
                            match_nxt = match_cnt + 4'd1;
                            timer_nxt = '0;
                            state_nxt = WAIT_RELEASE;
                        end else begin
                            state_nxt = LOST;
                        end
                    end else if (timer == TIMER_W'(TIMEOUT_CYCLES - 1)) begin
                        state_nxt = LOST;
                    end else begin
                        timer_nxt = timer + TIMER_W'(1);
                    end
                end
                WAIT_RELEASE: begin
                    if (keyStable == 4'b0000) begin
                        timer_nxt = '0;
                        state_nxt = (idx == size_l) ? WON : WAIT_PRESS;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign busy           = (state == WAIT_PRESS) || (state == WAIT_RELEASE);
    assign pressedQuarter = busy ? keyStable : 4'b0000;
    assign matchCount     = match_cnt;
    assign roundWon       = (state == WON);
    assign roundLost      = (state == LOST);

endmodule

// File: tb/tb_player_input_checker.sv
// Directed bench for player_input_checker with DEBOUNCE_CYCLES=4, TIMEOUT_CYCLES=100.
module tb_player_input_checker;
    import simon_pkg::*;

    logic             CLOCK_50;
    logic             resetn;
    logic             start;
    logic [SEQ_W-1:0] sequenceBits;
    logic [3:0]       sequenceSize;
    logic [3:0]       keys;
    logic [3:0]       pressedQuarter;
    logic             busy;
    logic [3:0]       matchCount;
    logic             roundWon;
    logic             roundLost;

    int n_cmp = 0;
    int n_err = 0;

    player_input_checker #(
        .DEBOUNCE_CYCLES(4),
        .TIMEOUT_CYCLES (100)
    ) dut (
        .CLOCK_50      (CLOCK_50),
        .resetn        (resetn),
        .start         (start),
        .sequenceBits  (sequenceBits),
        .sequenceSize  (sequenceSize),
        .keys          (keys),
        .pressedQuarter(pressedQuarter),
        .busy          (busy),
        .matchCount    (matchCount),
        .roundWon      (roundWon),
        .roundLost     (roundLost)
    );

    initial CLOCK_50 = 1'b0;
    always #5 CLOCK_50 = ~CLOCK_50;

    initial begin
        #2000000;
        $display("FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic tick(input int n);
        repeat (n) @(negedge CLOCK_50);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic restart();
        start = 1'b0;
        tick(1);
        start = 1'b1;
        tick(1);
    endtask

    task automatic tap(input logic [3:0] k);
        keys = k;
        tick(10);
        keys = 4'b0000;
        tick(10);
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_pq"},    32'(pressedQuarter), 32'h0);
        chk({tag, "_busy"},  32'(busy),           32'h0);
        chk({tag, "_match"}, 32'(matchCount),     32'h0);
        chk({tag, "_won"},   32'(roundWon),       32'h0);
        chk({tag, "_lost"},  32'(roundLost),      32'h0);
        chk({tag, "_state"}, 32'(dut.state),      32'(IDLE));
    endtask

    initial begin
        logic [SEQ_W-1:0] full_seq;
        resetn       = 1'b0;
        start        = 1'b0;
        keys         = 4'b0000;
        sequenceBits = '0;
        sequenceSize = 4'd0;
        tick(2);
        chk_quiet("reset");
        resetn = 1'b1;
        tick(1);

        // Full correct round: slots 0001, 0100, 1000.
        sequenceBits = 40'h00_0000_0841;
        sequenceSize = 4'd3;
        restart();
        chk("r1_busy", 32'(busy), 32'h1);
        chk("r1_match0", 32'(matchCount), 32'h0);
        keys = 4'b0001; tick(10);
        chk("r1_match1", 32'(matchCount), 32'h1);
        chk("r1_pq1", 32'(pressedQuarter), 32'h1);
        keys = 4'b0000; tick(10);
        chk("r1_pq_rel", 32'(pressedQuarter), 32'h0);
        chk("r1_busy_rel", 32'(busy), 32'h1);
        keys = 4'b0100; tick(10);
        chk("r1_match2", 32'(matchCount), 32'h2);
        keys = 4'b0000; tick(10);
        keys = 4'b1000; tick(10);
        chk("r1_match3", 32'(matchCount), 32'h3);
        chk("r1_won_held", 32'(roundWon), 32'h0);
        keys = 4'b0000; tick(10);
        chk("r1_won", 32'(roundWon), 32'h1);
        chk("r1_busy_won", 32'(busy), 32'h0);
        chk("r1_match_frozen", 32'(matchCount), 32'h3);
        tick(20);
        chk("r1_won_hold", 32'(roundWon), 32'h1);

        // Wrong key on slot 1: exact 7-cycle latency from raw press.
        restart();
        chk("wk_won_clr", 32'(roundWon), 32'h0);
        chk("wk_busy", 32'(busy), 32'h1);
        tap(4'b0001);
        chk("wk_match1", 32'(matchCount), 32'h1);
        keys = 4'b0010;
        tick(6);
        chk("wk_lost_early", 32'(roundLost), 32'h0);
        tick(1);
        chk("wk_lost", 32'(roundLost), 32'h1);
        chk("wk_match", 32'(matchCount), 32'h1);
        chk("wk_busy0", 32'(busy), 32'h0);
        chk("wk_pq0", 32'(pressedQuarter), 32'h0);
        keys = 4'b0000; tick(10);

        // Timeout: LOST exactly 100 cycles after entering WAIT_PRESS.
        restart();
        tick(98);
        chk("to_98", 32'(roundLost), 32'h0);
        tick(1);
        chk("to_99", 32'(roundLost), 32'h0);
        tick(1);
        chk("to_100", 32'(roundLost), 32'h1);
        chk("to_busy", 32'(busy), 32'h0);

        // Press evaluated on timer cycle 99 wins over the timeout.
        restart();
        tick(93);
        keys = 4'b0001;
        tick(6);
        chk("to_press_pending", 32'(roundLost), 32'h0);
        tick(1);
        chk("to_press_match", 32'(matchCount), 32'h1);
        chk("to_press_lost", 32'(roundLost), 32'h0);
        chk("to_press_busy", 32'(busy), 32'h1);
        keys = 4'b0000; tick(10);

        // Bounce: only the settled press counts.
        restart();
        for (int i = 0; i < 5; i++) begin
            keys = 4'b0001; tick(2);
            keys = 4'b0000; tick(2);
        end
        chk("bn_no_evt", 32'(matchCount), 32'h0);
        keys = 4'b0001; tick(10);
        chk("bn_match", 32'(matchCount), 32'h1);
        chk("bn_lost", 32'(roundLost), 32'h0);
        keys = 4'b0000; tick(10);
        chk("bn_still_busy", 32'(busy), 32'h1);
        chk("bn_lost2", 32'(roundLost), 32'h0);

        // Multi-key press containing the right bit is still wrong.
        restart();
        keys = 4'b0011; tick(10);
        chk("mk_lost", 32'(roundLost), 32'h1);
        chk("mk_match", 32'(matchCount), 32'h0);
        keys = 4'b0000; tick(10);

        // Size 0 wins immediately.
        sequenceSize = 4'd0;
        restart();
        chk("sz0_won", 32'(roundWon), 32'h1);
        chk("sz0_busy", 32'(busy), 32'h0);

        // Size 12 clamps to 10 slots.
        full_seq     = 40'h21_8421_8421;
        sequenceBits = full_seq;
        sequenceSize = 4'd12;
        restart();
        for (int i = 0; i < 10; i++) begin
            logic [SEQ_W-1:0] sh;
            sh = full_seq >> (4 * i);
            tap(sh[3:0]);
            chk("clamp_match", 32'(matchCount), 32'(i + 1));
            if (i < 9) chk("clamp_busy", 32'(busy), 32'h1);
        end
        chk("clamp_won", 32'(roundWon), 32'h1);

        // Start edge mid-round restarts from slot 0.
        sequenceBits = 40'h00_0000_0841;
        sequenceSize = 4'd3;
        restart();
        tap(4'b0001);
        chk("mid_match1", 32'(matchCount), 32'h1);
        restart();
        chk("mid_match0", 32'(matchCount), 32'h0);
        chk("mid_busy", 32'(busy), 32'h1);
        tap(4'b0001);
        chk("mid_rematch", 32'(matchCount), 32'h1);
        chk("mid_lost", 32'(roundLost), 32'h0);

        // Reset while holding the second key in WAIT_RELEASE.
        restart();
        tap(4'b0001);
        keys = 4'b0100; tick(10);
        chk("rst_pre_match", 32'(matchCount), 32'h2);
        chk("rst_pre_pq", 32'(pressedQuarter), 32'h4);
        resetn = 1'b0;
        start  = 1'b0;
        tick(1);
        resetn = 1'b1;
        chk_quiet("rst_mid");
        keys = 4'b0000; tick(10);
        chk_quiet("rst_after");
        restart();
        chk("rst_fresh_busy", 32'(busy), 32'h1);
        chk("rst_fresh_match0", 32'(matchCount), 32'h0);
        tap(4'b0001);
        chk("rst_fresh_match1", 32'(matchCount), 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
